// File: rtl/vreg_wb_arbiter_if.sv
// Write-back bus bundle for vreg_wb_arbiter: ALU vector port, load word port,
// issue/check scoreboard port and the register-file write port.
// Latency: none (wiring only). Backpressure: alu_ready / ld_ready driven by the slave.
interface vreg_wb_arbiter_if;
    logic              alu_valid;
    logic [3:0]        alu_addr;
    logic [3:0][31:0]  alu_data;   // lane 0 is [0]
    logic              alu_ready;
    logic              ld_valid;
    logic [3:0]        ld_addr;
    logic [31:0]       ld_word;
    logic              ld_ready;
    logic              iss_valid;
    logic [3:0]        iss_addr;
    logic [3:0]        chk_addr1;
    logic [3:0]        chk_addr2;
    logic              hazard1;
    logic              hazard2;
    logic [15:0]       busy;
    logic              wren;
    logic [3:0]        wraddr;
    logic [3:0][31:0]  wrdata;

    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_word,
               iss_valid, iss_addr, chk_addr1, chk_addr2,
        output alu_ready, ld_ready, hazard1, hazard2, busy, wren, wraddr, wrdata
    );

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_word,
               iss_valid, iss_addr, chk_addr1, chk_addr2,
        input  alu_ready, ld_ready, hazard1, hazard2, busy, wren, wraddr, wrdata
    );
endinterface

// File: rtl/vreg_wb_arbiter.sv
// Write-back arbiter: ALU vectors and assembled 4-word loads share one VRF write port; RAW scoreboard.
// Latency: ALU grant -> wren next cycle; load FULL one cycle after 4th word, then granted like ALU.
// Backpressure: ld_ready low while buffer FULL; alu_ready low only when FULL and priority is load.
// Ports: clk, rst_n (async active-low); bus = vreg_wb_arbiter_if.slave carrying
//        ALU/load requests, issue/check scoreboard signals and registered wren/wraddr/wrdata.
module vreg_wb_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    vreg_wb_arbiter_if.slave bus
);
    typedef enum logic { COLLECT = 1'b0, FULL = 1'b1 } ld_state_t;
    typedef enum logic { PRIO_ALU = 1'b0, PRIO_LD = 1'b1 } prio_t;

    ld_state_t         state, state_nxt;
    logic [1:0]        cnt;
    logic [3:0][31:0]  lbuf;
    logic [3:0]        laddr;
    prio_t             prio;

    logic              ld_acc;
    logic              cand_ld;
    logic              grant_alu;
    logic              grant_ld;
    logic [15:0]       busy_nxt;

    assign cand_ld   = (state == FULL);
    assign ld_acc    = bus.ld_valid & bus.ld_ready;
    // Both candidates present: prio decides; otherwise the lone candidate wins.
    assign grant_alu = bus.alu_valid & (!cand_ld | (prio == PRIO_ALU));
    assign grant_ld  = cand_ld & (!bus.alu_valid | (prio == PRIO_LD));

    // Independent of alu_valid so the ALU can use it as a plain ready.
    assign bus.alu_ready = !(cand_ld && (prio == PRIO_LD));
    assign bus.ld_ready  = (state == COLLECT);

    // Scoreboard lookups see only the registered bits; no bypass from the current write.
    assign bus.hazard1 = bus.busy[bus.chk_addr1];
    assign bus.hazard2 = bus.busy[bus.chk_addr2];

    // Load assembler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (ld_acc && cnt == 2'd3) state_nxt = FULL;
            FULL:    if (grant_ld)              state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Load datapath: lane buffer, lane counter, destination captured on first word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            lbuf  <= '0;
            laddr <= 4'd0;
        end else if (ld_acc) begin
            lbuf[cnt] <= bus.ld_word;
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd0) laddr <= bus.ld_addr;
        end
    end

    // Priority flips to the other side after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         prio <= PRIO_ALU;
        else if (grant_alu) prio <= PRIO_LD;
        else if (grant_ld)  prio <= PRIO_ALU;
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wren   <= 1'b0;
            bus.wraddr <= 4'd0;
            bus.wrdata <= '0;
        end else begin
            bus.wren <= grant_alu | grant_ld;
            if (grant_alu) begin
                bus.wraddr <= bus.alu_addr;
                bus.wrdata <= bus.alu_data;
            end else if (grant_ld) begin
                bus.wraddr <= laddr;
                bus.wrdata <= lbuf;
            end
        end
    end

    // Clear applied before set so a same-edge issue keeps the register pending.
    always_comb begin
        busy_nxt = bus.busy;
        if (bus.wren)      busy_nxt[bus.wraddr]   = 1'b0;
        if (bus.iss_valid) busy_nxt[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.busy <= 16'd0;
        else        bus.busy <= busy_nxt;
    end
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
module tb_vreg_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    vreg_wb_arbiter_if bus ();

    vreg_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_addr  = 4'd0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = 4'd0;
        bus.ld_word   = 32'd0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = 4'd0;
        bus.chk_addr1 = 4'd0;
        bus.chk_addr2 = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [3:0][31:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                             input logic [31:0] l2, input logic [31:0] l3);
        logic [3:0][31:0] v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        return v;
    endfunction

    // Present four load words; first carries addr a0, later ones carry a decoy address.
    task automatic load4(input logic [3:0] a0, input logic [31:0] base, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = (i == 0) ? a0 : 4'd3;
            bus.ld_word  = base + i;
            #1;
            chk({tag, "_ld_ready_collect"}, {127'd0, bus.ld_ready}, 128'd1);
            tick();
        end
        bus.ld_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        // ---------------- reset values
        chk("rst_wren",      {127'd0, bus.wren},      128'd0);
        chk("rst_wraddr",    {124'd0, bus.wraddr},    128'd0);
        chk("rst_wrdata",    bus.wrdata,              128'd0);
        chk("rst_busy",      {112'd0, bus.busy},      128'd0);
        chk("rst_ld_ready",  {127'd0, bus.ld_ready},  128'd1);
        chk("rst_alu_ready", {127'd0, bus.alu_ready}, 128'd1);
        do_reset();

        // ---------------- ALU write
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd5;
        bus.alu_data  = vec(32'd1, 32'd2, 32'd3, 32'd4);
        #1;
        chk("alu_ready", {127'd0, bus.alu_ready}, 128'd1);
        chk("alu_pre_wren", {127'd0, bus.wren}, 128'd0);
        tick();
        bus.alu_valid = 1'b0;
        chk("alu_wren",   {127'd0, bus.wren},   128'd1);
        chk("alu_wraddr", {124'd0, bus.wraddr}, 128'd5);
        chk("alu_wrdata", bus.wrdata, vec(32'd1, 32'd2, 32'd3, 32'd4));
        tick();
        chk("alu_wren_off",    {127'd0, bus.wren},   128'd0);
        chk("alu_wraddr_hold", {124'd0, bus.wraddr}, 128'd5);

        // ---------------- load assembly
        do_reset();
        load4(4'd9, 32'hA0, "ld");
        chk("ld_ready_full", {127'd0, bus.ld_ready}, 128'd0);
        chk("ld_full_wren",  {127'd0, bus.wren},     128'd0);
        tick();
        chk("ld_wren",     {127'd0, bus.wren},     128'd1);
        chk("ld_wraddr",   {124'd0, bus.wraddr},   128'd9);
        chk("ld_wrdata",   bus.wrdata, vec(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        chk("ld_ready_back", {127'd0, bus.ld_ready}, 128'd1);
        tick();
        chk("ld_wren_off", {127'd0, bus.wren}, 128'd0);

        // ---------------- contention, prio starts at ALU
        do_reset();
        load4(4'd6, 32'hC0, "ct");
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd2;
        bus.alu_data  = vec(32'h11, 32'h12, 32'h13, 32'h14);
        #1;
        chk("ct_alu_ready1", {127'd0, bus.alu_ready}, 128'd1);
        tick();
        bus.alu_data = vec(32'h21, 32'h22, 32'h23, 32'h24);
        #1;
        chk("ct_w1_addr", {124'd0, bus.wraddr}, 128'd2);
        chk("ct_w1_data", bus.wrdata, vec(32'h11, 32'h12, 32'h13, 32'h14));
        chk("ct_alu_ready0", {127'd0, bus.alu_ready}, 128'd0);
        tick();
        chk("ct_w2_wren", {127'd0, bus.wren},   128'd1);
        chk("ct_w2_addr", {124'd0, bus.wraddr}, 128'd6);
        chk("ct_w2_data", bus.wrdata, vec(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        chk("ct_alu_ready2", {127'd0, bus.alu_ready}, 128'd1);
        tick();
        bus.alu_valid = 1'b0;
        chk("ct_w3_wren", {127'd0, bus.wren},   128'd1);
        chk("ct_w3_addr", {124'd0, bus.wraddr}, 128'd2);
        chk("ct_w3_data", bus.wrdata, vec(32'h21, 32'h22, 32'h23, 32'h24));
        tick();
        chk("ct_idle_wren", {127'd0, bus.wren}, 128'd0);

        // ---------------- scoreboard
        do_reset();
        bus.chk_addr1 = 4'd7;
        bus.chk_addr2 = 4'd7;
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 4'd7;
        #1;
        chk("sb_haz_pre", {127'd0, bus.hazard1}, 128'd0);
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_haz_a",  {127'd0, bus.hazard1}, 128'd1);
        chk("sb_busy_a", {112'd0, bus.busy},    128'h0080);
        tick();
        chk("sb_haz_b",  {127'd0, bus.hazard1}, 128'd1);
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd7;
        bus.alu_data  = vec(32'h70, 32'h71, 32'h72, 32'h73);
        tick();
        bus.alu_valid = 1'b0;
        chk("sb_wren",     {127'd0, bus.wren},    128'd1);
        chk("sb_haz_wren", {127'd0, bus.hazard1}, 128'd1);
        tick();
        chk("sb_haz_clr",  {127'd0, bus.hazard1}, 128'd0);
        chk("sb_busy_clr", {112'd0, bus.busy},    128'd0);
        // same-edge set and clear on register 7
        bus.iss_valid = 1'b1;
        tick();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1;
        tick();
        bus.alu_valid = 1'b0;
        bus.iss_valid = 1'b1;
        chk("sb_same_wren", {127'd0, bus.wren}, 128'd1);
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_same_busy", {112'd0, bus.busy},    128'h0080);
        chk("sb_same_haz2", {127'd0, bus.hazard2}, 128'd1);
        tick();
        chk("sb_same_hold", {112'd0, bus.busy},    128'h0080);

        // ---------------- reset mid-load
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 4'd4;
            bus.ld_word  = 32'hA0 + i;
            tick();
        end
        bus.ld_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rm_ld_ready", {127'd0, bus.ld_ready}, 128'd1);
        load4(4'd1, 32'hB0, "rm");
        chk("rm_full", {127'd0, bus.ld_ready}, 128'd0);
        tick();
        chk("rm_wren",   {127'd0, bus.wren},   128'd1);
        chk("rm_wraddr", {124'd0, bus.wraddr}, 128'd1);
        chk("rm_wrdata", bus.wrdata, vec(32'hB0, 32'hB1, 32'hB2, 32'hB3));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
